// File: rtl/loong_pkg.sv
// Shared types and helpers for the LOONG round-constant generator.
// The LFSR step and row constant live here so every unit agrees on them.
package loong_pkg;

   localparam int LFSR_W = 6;
   localparam logic [LFSR_W-1:0] RC_INIT = 6'h01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      EMIT = 2'd2
   } state_t;

   function automatic logic [LFSR_W-1:0] rc_step(
      input logic [LFSR_W-1:0] rc
   );
      return {rc[4:0], ~(rc[5] ^ rc[4])};
   endfunction

   function automatic int unsigned row_const(input int r);
      return (r == 0) ? 0 : (32'd1 << (r - 1));
   endfunction

endpackage

// File: rtl/loong_rc_gen_if.sv
// Round-controller side bundle of the constant generator:
// start request, constant handshake and status pulses.
interface loong_rc_gen_if #(
   parameter int IW       = 6,
   parameter int DIM      = 4,
   parameter int NIBBLE_W = 4
);
   logic                                  start;
   logic [IW-1:0]                         start_round;
   logic                                  rc_ready;
   logic                                  rc_valid;
   logic [0:DIM-1][0:DIM-1][NIBBLE_W-1:0] round_cnst;
   logic [IW-1:0]                         round_idx;
   logic                                  busy;
   logic                                  done;
   logic                                  err;

   modport master (
      output start, start_round, rc_ready,
      input  rc_valid, round_cnst, round_idx, busy, done, err
   );

   modport slave (
      input  start, start_round, rc_ready,
      output rc_valid, round_cnst, round_idx, busy, done, err
   );
endinterface

// File: rtl/loong_rc_lfsr.sv
// 6-bit round-constant LFSR with synchronous reload to the seed
// and an advance enable; load wins over en.
module loong_rc_lfsr
   import loong_pkg::*;
(
   input  logic              clock,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   output logic [LFSR_W-1:0] rc
);

   // Seed on reset or load, advance one step when enabled.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         rc <= RC_INIT;
      end else if (load) begin
         rc <= RC_INIT;
      end else if (en) begin
         rc <= rc_step(rc);
      end
   end

endmodule

// File: rtl/loong_rc_gen.sv
// Round-constant generator: FSM seeks to the first round, then
// streams one DIM x DIM constant matrix per accepted handshake.
module loong_rc_gen
   import loong_pkg::*;
#(
   parameter int ROUNDS   = 33,
   parameter int DIM      = 4,
   parameter int NIBBLE_W = 4,
   parameter int MODE     = 0,
   parameter int IW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input logic           clock,
   input logic           rst,
   loong_rc_gen_if.slave bus
);

   typedef logic [0:DIM-1][0:DIM-1][NIBBLE_W-1:0] mat_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     tgt_q, tgt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              lfsr_load, lfsr_en;
   logic [LFSR_W-1:0] rc;
   logic              valid, fire, last, bad;
   mat_t              cnst;

   loong_rc_lfsr u_lfsr (
      .clock (clock),
      .rst   (rst),
      .load  (lfsr_load),
      .en    (lfsr_en),
      .rc    (rc)
   );

   assign valid = (state_q == EMIT);
   assign fire  = valid && bus.rc_ready;
   assign last  = (cnt_q == IW'(ROUNDS - 1));
   assign bad   = {1'b0, bus.start_round} >= (IW + 1)'(ROUNDS);

   // State, round counter, seek target and status pulses.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next state: seek walks the LFSR up to the first requested round.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tgt_d     = tgt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bad) begin
                  err_d = 1'b1;
               end else begin
                  lfsr_load = 1'b1;
                  cnt_d     = '0;
                  tgt_d     = bus.start_round;
                  state_d   = (bus.start_round == '0) ? EMIT : SEEK;
               end
            end
         end
         SEEK: begin
            lfsr_en = 1'b1;
            cnt_d   = cnt_q + IW'(1);
            if (cnt_d == tgt_q) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (fire) begin
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  lfsr_en = 1'b1;
                  cnt_d   = cnt_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Matrix decode: shifted-one column plus LFSR-field column, zero outside EMIT.
   always_comb begin
      cnst = '0;
      if (valid) begin
         for (int r = 0; r < DIM; r++) begin
            cnst[r][DIM-2] = NIBBLE_W'(row_const(r));
            if (MODE == 0) begin
               cnst[r][DIM-1] = (r % 2 == 0) ? NIBBLE_W'(|rc[5:3])
                                             : NIBBLE_W'(|rc[2:0]);
            end else begin
               cnst[r][DIM-1] = (r % 2 == 0) ? NIBBLE_W'(rc[5:3])
                                             : NIBBLE_W'(rc[2:0]);
            end
         end
      end
   end

   assign bus.rc_valid   = valid;
   assign bus.round_cnst = cnst;
   assign bus.round_idx  = cnt_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_loong_rc_gen.sv
// Bench for loong_rc_gen: MODE 0 and MODE 1 instances share one
// stimulus; a round queue plus LFSR table predicts every transfer.
module tb_loong_rc_gen;

   localparam int ROUNDS = 33;
   localparam int DIM    = 4;
   localparam int NW     = 4;
   localparam int IW     = $clog2(ROUNDS);

   typedef logic [0:DIM-1][0:DIM-1][NW-1:0] mat_t;

   logic          clock = 1'b0;
   logic          rst;
   logic          start;
   logic [IW-1:0] start_round;
   logic          rc_ready;

   int checks   = 0;
   int failures = 0;
   int ref_rc[64];
   int exp_q[$];
   bit done_pend  = 1'b0;
   bit prev_stall = 1'b0;
   int prev_idx   = 0;
   mat_t prev_m0, prev_m1;
   int xfers = 0;
   int n;

   loong_rc_gen_if #(.IW(IW), .DIM(DIM), .NIBBLE_W(NW)) i0 ();
   loong_rc_gen_if #(.IW(IW), .DIM(DIM), .NIBBLE_W(NW)) i1 ();

   assign i0.start       = start;
   assign i0.start_round = start_round;
   assign i0.rc_ready    = rc_ready;
   assign i1.start       = start;
   assign i1.start_round = start_round;
   assign i1.rc_ready    = rc_ready;

   loong_rc_gen #(
      .ROUNDS(ROUNDS), .DIM(DIM), .NIBBLE_W(NW), .MODE(0)
   ) u0 (
      .clock (clock),
      .rst   (rst),
      .bus   (i0.slave)
   );

   loong_rc_gen #(
      .ROUNDS(ROUNDS), .DIM(DIM), .NIBBLE_W(NW), .MODE(1)
   ) u1 (
      .clock (clock),
      .rst   (rst),
      .bus   (i1.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic mat_t exp_mat(input int mode, input int rc);
      mat_t m;
      int   f;
      m = '0;
      for (int r = 0; r < DIM; r++) begin
         f = (r % 2 == 0) ? (rc / 8) % 8 : rc % 8;
         if (r > 0) m[r][DIM-2] = NW'(2 ** (r - 1));
         m[r][DIM-1] = (mode == 0) ? NW'(f != 0) : NW'(f);
      end
      return m;
   endfunction

   // Compare process: every negedge, check against the round queue.
   always @(negedge clock) begin
      int idx;
      chk("done0", i0.done, done_pend);
      chk("done1", i1.done, done_pend);
      chk("valid_match", i1.rc_valid, i0.rc_valid);
      if (i0.done) begin
         chk("busy_at_done", i0.busy, 0);
         chk("valid_at_done", i0.rc_valid, 0);
      end
      if (i0.rc_valid) begin
         chk("valid_expected", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            idx = exp_q[0];
            chk("idx0", i0.round_idx, idx);
            chk("idx1", i1.round_idx, idx);
            chk("mat0", i0.round_cnst, exp_mat(0, ref_rc[idx]));
            chk("mat1", i1.round_cnst, exp_mat(1, ref_rc[idx]));
         end
         if (prev_stall) begin
            chk("stall_idx", i0.round_idx, prev_idx);
            chk("stall_m0", i0.round_cnst, prev_m0);
            chk("stall_m1", i1.round_cnst, prev_m1);
         end
      end
      done_pend = 1'b0;
      if (i0.rc_valid && rc_ready && exp_q.size() != 0) begin
         if (exp_q[0] == ROUNDS - 1) done_pend = 1'b1;
         void'(exp_q.pop_front());
         xfers++;
      end
      prev_stall = i0.rc_valid && !rc_ready;
      prev_idx   = int'(i0.round_idx);
      prev_m0    = i0.round_cnst;
      prev_m1    = i1.round_cnst;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input int k);
      start       = 1'b1;
      start_round = IW'(k);
      for (int i = k; i < ROUNDS; i++) exp_q.push_back(i);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!i0.rc_valid && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_done(input string nm);
      int c = 0;
      while (!i0.done && c < 200) begin
         tick();
         c++;
      end
      chk(nm, i0.done, 1);
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_valid"}, {i0.rc_valid, i1.rc_valid}, 0);
      chk({nm, "_busy"}, {i0.busy, i1.busy}, 0);
      chk({nm, "_done"}, {i0.done, i1.done}, 0);
      chk({nm, "_err"}, {i0.err, i1.err}, 0);
      chk({nm, "_idx"}, {i0.round_idx, i1.round_idx}, 0);
      chk({nm, "_m0"}, i0.round_cnst, 0);
      chk({nm, "_m1"}, i1.round_cnst, 0);
   endtask

   task automatic hit_reset();
      rst = 1'b0;
      exp_q.delete();
      done_pend = 1'b0;
      #1;
   endtask

   initial begin
      ref_rc[0] = 1;
      for (int i = 1; i < 64; i++) begin
         int x;
         x = ref_rc[i-1];
         ref_rc[i] = ((x * 2) % 64)
                   + ((((x / 32) % 2) == ((x / 16) % 2)) ? 1 : 0);
      end
      chk("ref5", ref_rc[5], 'h3E);
      chk("ref6", ref_rc[6], 'h3D);
      chk("ref25", ref_rc[25], 'h02);
      chk("ref32", ref_rc[32], 'h31);
      chk("ref25_m0", exp_mat(0, ref_rc[25]), 64'h0000_0011_0020_0041);

      rst         = 1'b0;
      start       = 1'b0;
      start_round = '0;
      rc_ready    = 1'b0;
      repeat (3) tick();
      chk_rst("por");
      rst = 1'b1;
      tick();

      // full schedule from round 0, consumer always ready
      rc_ready = 1'b1;
      xfers    = 0;
      do_start(0);
      wait_valid(n);
      chk("lat0", n, 1);
      chk("r0_m0", i0.round_cnst, 64'h0000_0011_0020_0041);
      chk("r0_m1", i1.round_cnst, 64'h0000_0011_0020_0041);
      wait_done("done_full");
      chk("xfers_full", xfers, ROUNDS);
      tick();

      // start at round 5, stall, and an ignored start while busy
      do_start(5);
      wait_valid(n);
      chk("lat5", n, 6);
      chk("r5_idx", i1.round_idx, 5);
      chk("r5_m1", i1.round_cnst, 64'h0007_0016_0027_0046);
      tick();
      chk("r6_idx", i1.round_idx, 6);
      chk("r6_m1", i1.round_cnst, 64'h0007_0015_0027_0045);
      rc_ready = 1'b0;
      repeat (4) tick();
      chk("stall_hold_idx", i0.round_idx, 6);
      start       = 1'b1;
      start_round = '0;
      tick();
      start    = 1'b0;
      rc_ready = 1'b1;
      wait_done("done_r5");
      tick();

      // last round only, then restart in the done cycle
      do_start(32);
      wait_valid(n);
      chk("lat32", n, 33);
      chk("r32_m1", i1.round_cnst, 64'h0006_0011_0026_0041);
      tick();
      chk("done_r32", i0.done, 1);
      chk("busy_r32", i0.busy, 0);
      do_start(0);
      wait_valid(n);
      chk("lat_restart", n, 1);
      wait_done("done_restart");
      tick();

      // out-of-range start
      do_start(40);
      chk("err_pulse", {i0.err, i1.err}, 2'b11);
      chk("err_busy", i0.busy, 0);
      tick();
      chk("err_clear", i0.err, 0);

      // reset during SEEK
      do_start(20);
      repeat (5) tick();
      chk("seek_busy", i0.busy, 1);
      hit_reset();
      chk_rst("rst_seek");
      tick();
      rst = 1'b1;
      tick();

      // reset during EMIT
      rc_ready = 1'b0;
      do_start(3);
      wait_valid(n);
      chk("lat3", n, 4);
      repeat (2) tick();
      hit_reset();
      chk_rst("rst_emit");
      tick();
      rst = 1'b1;
      tick();

      // clean restart after reset
      rc_ready = 1'b1;
      do_start(0);
      wait_valid(n);
      chk("lat_post", n, 1);
      chk("post_idx", i0.round_idx, 0);
      chk("post_m1", i1.round_cnst, 64'h0000_0011_0020_0041);
      wait_done("done_post");
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
